// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared definitions for parity blocks. It holds the frame state
//               encoding, a helper for the word-count width and the even/odd
//               parity error function.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    // Frame-checker state encoding (explicit width, legacy-compatible constants)
    typedef logic [1:0] state_t;
    localparam state_t c_stIdle   = 2'd0;
    localparam state_t c_stAccum  = 2'd1;
    localparam state_t c_stReport = 2'd2;

    // Bits needed to hold a word count from 0 up to maxWords inclusive
    function automatic int cntWidth(input int maxWords);
        return (maxWords < 1) ? 1 : $clog2(maxWords + 1);
    endfunction

    // Parity error for a computed parity against the transmitted bit.
    // Even mode flags any difference. Odd mode flags agreement, because a
    // correct odd frame has total parity (data plus parity bit) equal to one.
    function automatic logic parityErr(input logic parity, input logic sentPar,
                                       input logic oddMode);
        return oddMode ? ~(parity ^ sentPar) : (parity ^ sentPar);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. Clear has
//               priority over increment. The count stops at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] c_maxVal = '1;

    logic [WIDTH-1:0] r_value;

    // Count up on inc, hold at the maximum, clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != c_maxVal)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_checker
// Description : Streaming frame parity checker. It XOR-accumulates DATA_W-bit
//               words over a valid/ready handshake and checks the result
//               against the transmitted parity bit at frame end. It emits a
//               one-cycle result strobe and keeps a saturating error count.
//               Optional macro PARITY_WORD_CHECK_EN adds per-word parity
//               checking (in_wpar / res_werr).
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int ODD_MODE  = 0,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_last,
    input  logic                              in_par,
`ifdef PARITY_WORD_CHECK_EN
    input  logic                              in_wpar,
    output logic                              res_werr,
`endif
    input  logic                              clr_cnt,
    output logic                              res_valid,
    output logic                              res_err,
    output logic                              res_ovf,
    output logic                              res_parity,
    output logic [cntWidth(MAX_WORDS)-1:0]    res_words,
    output logic [CNT_W-1:0]                  err_cnt
);

    localparam int                c_cntW     = cntWidth(MAX_WORDS);
    localparam logic [c_cntW-1:0] c_maxWords = c_cntW'(MAX_WORDS);
    localparam logic              c_oddMode  = (ODD_MODE != 0);

    state_t              r_state;
    logic                r_acc;
    logic [c_cntW-1:0]   r_cnt;
    logic                r_resErr;
    logic                r_resOvf;
    logic                r_resParity;
    logic [c_cntW-1:0]   r_resWords;
    logic                r_werr;
    logic                r_resWerr;

    logic                w_accept;
    logic                w_accNext;
    logic [c_cntW-1:0]   w_cntNext;
    logic                w_close;
    logic                w_parErr;
    logic                w_werrNext;

    // Handshake, running parity and frame-close decision for the current beat
    always_comb begin
        w_accept  = in_valid && (r_state != c_stReport);
        w_accNext = r_acc ^ (^in_data);
        w_cntNext = r_cnt + 1'b1;
        // The MAX_WORDS-th beat closes the frame even without in_last
        w_close   = in_last || (w_cntNext == c_maxWords);
        w_parErr  = parityErr(w_accNext, in_par, c_oddMode);
`ifdef PARITY_WORD_CHECK_EN
        w_werrNext = r_werr | parityErr(^in_data, in_wpar, c_oddMode);
`else
        w_werrNext = 1'b0;
`endif
    end

    // Frame state machine, accumulator and result capture on the closing beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_stIdle;
            r_acc       <= 1'b0;
            r_cnt       <= '0;
            r_resErr    <= 1'b0;
            r_resOvf    <= 1'b0;
            r_resParity <= 1'b0;
            r_resWords  <= '0;
            r_werr      <= 1'b0;
            r_resWerr   <= 1'b0;
        end else begin
            case (r_state)
                c_stIdle, c_stAccum: begin
                    if (w_accept) begin
                        if (w_close) begin
                            // Results are latched here so they are visible
                            // during REPORT and hold until the next frame.
                            r_state     <= c_stReport;
                            r_resParity <= w_accNext;
                            r_resWords  <= w_cntNext;
                            r_resOvf    <= ~in_last;
                            // On overflow the parity bit is ignored
                            r_resErr    <= (~in_last) | w_parErr | w_werrNext;
                            r_resWerr   <= w_werrNext;
                            r_acc       <= 1'b0;
                            r_cnt       <= '0;
                            r_werr      <= 1'b0;
                        end else begin
                            r_state <= c_stAccum;
                            r_acc   <= w_accNext;
                            r_cnt   <= w_cntNext;
                            r_werr  <= w_werrNext;
                        end
                    end
                end
                c_stReport: begin
                    r_state <= c_stIdle;
                end
                default: begin
                    r_state <= c_stIdle;
                end
            endcase
        end
    end

    assign in_ready   = (r_state != c_stReport);
    assign res_valid  = (r_state == c_stReport);
    assign res_err    = r_resErr;
    assign res_ovf    = r_resOvf;
    assign res_parity = r_resParity;
    assign res_words  = r_resWords;
`ifdef PARITY_WORD_CHECK_EN
    assign res_werr   = r_resWerr;
`endif

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_errCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (res_valid && r_resErr),
        .clr   (clr_cnt),
        .value (err_cnt)
    );

endmodule
`default_nettype wire

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Streaming, parametrised successor to the team's 4-bit even-parity checker.
- Accepts DATA_W-bit words over a valid/ready handshake and accumulates XOR parity across a multi-word frame.
- At frame end, compares the accumulated parity against a transmitted parity bit in even or odd mode and reports a one-cycle result.
- Keeps a saturating error counter; sits between a framed serial receiver and the link-status logic.

Parameters:
- DATA_W, 4: width of each data word.
- ODD_MODE, 0: 0 = even parity frames, 1 = odd parity frames.
- MAX_WORDS, 16: maximum words per frame, >=1; beats beyond this force frame end with overflow.
- CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  data word.
- in_last  in  1  final word of frame.
- in_par  in  1  transmitted frame parity bit, sampled only on the accepted in_last beat.
- clr_cnt  in  1  synchronous clear of err_cnt.
- res_valid  out  1  one-cycle frame result strobe.
- res_err  out  1  parity mismatch or overflow, qualified by res_valid.
- res_ovf  out  1  frame exceeded MAX_WORDS, qualified by res_valid.
- res_parity  out  1  XOR of all data bits of the frame, excluding in_par.
- res_words  out  $clog2(MAX_WORDS+1)  words counted in the frame.
- err_cnt  out  CNT_W  saturating count of errored frames.

Behaviour:
- Single clock domain; one clock `clk`, reset `rst_n` synchronous and active-low.
- Reset values:
  - State IDLE; accumulator 0; word count 0.
  - in_ready=1.
  - res_valid, res_err, res_ovf, res_parity = 0; res_words = 0; err_cnt = 0.
- Accept rule: a beat is accepted when in_valid && in_ready. Data is ignored otherwise.
- State machine:
  - IDLE: in_ready=1. An accepted non-last beat moves to ACCUM. An accepted last beat moves to REPORT.
  - ACCUM: in_ready=1. An accepted last beat, or the accepted beat that brings the count to MAX_WORDS, moves to REPORT.
  - REPORT: in_ready=0, res_valid=1 for exactly one cycle, then IDLE with accumulator and count cleared.
- Accumulation: acc_next = acc ^ (^in_data); count increments per accepted beat.
- Error evaluation on the closing beat:
  - Even mode: err = acc_next ^ in_par.
  - Odd mode: err = ~(acc_next ^ in_par).
- Overflow: if the MAX_WORDS-th beat has in_last=0, the frame is closed with res_ovf=1 and res_err=1, and in_par is ignored. Later beats start a new frame.
- Overflow boundary: if the MAX_WORDS-th beat has in_last=1, the frame closes normally with res_ovf=0.
- Latency: the closing beat is accepted at cycle N; res_valid is high at N+1; the next beat can be accepted at N+2.
- Result outputs hold their values after the strobe until the next REPORT. Only res_valid pulses.
- err_cnt:
  - +1 on the res_valid && res_err cycle; saturates at 2^CNT_W-1.
  - clr_cnt has priority over an increment in the same cycle, so the result is 0.
- Reset mid-frame discards the partial frame and produces no result.
- MAX_WORDS=1: every beat closes a frame.

Optional Feature:
- Macro: PARITY_WORD_CHECK_EN.
- When defined:
  - Adds input in_wpar (1 bit, per-word even/odd parity per ODD_MODE) and output res_werr.
  - Any accepted word whose parity mismatches sets a sticky frame flag. That flag sets res_werr and also forces res_err in REPORT.
- When undefined: neither port exists, and behaviour is exactly as above.

Decomposition:
- Shared package parity_pkg holds:
  - The state enum (IDLE, ACCUM, REPORT).
  - Localparam helper for the count width.
  - A function computing even/odd error from parity and mode, reusable by future parity blocks.
- Sub-module sat_counter (width param, inc, clr, value) implements err_cnt and is reusable elsewhere.

Test Plan:
- Even, 2-word frame: words 4'b1011, 4'b0001 (last), in_par=0 -> res_valid 1 cycle after the last beat; res_err=0, res_parity=0, res_words=2, err_cnt=0.
- Same frame with in_par=1 -> res_err=1, err_cnt=1. Repeat with ODD_MODE=1 and in_par=1 -> res_err=0.
- MAX_WORDS=4: send 5 words with in_last never set -> result after the 4th beat with res_ovf=1, res_err=1, res_words=4; the 5th word starts a new frame with res_words=1.
- Back-to-back frames with in_valid held high -> in_ready=0 exactly during the REPORT cycle; no beat lost or duplicated.
- CNT_W=2: 5 errored frames -> err_cnt sticks at 3. clr_cnt asserted in the same cycle as an error strobe -> err_cnt=0.
- rst_n low after 2 beats of a frame -> no res_valid. A following 1-word frame 4'b0111 with in_par=1 reports res_err=0 and res_words=1.
